// File: rtl/pim_pkg.sv
// Shared definitions for the PIM tile datapath: MAC state encoding,
// default geometry constants and the saturating add helper used when
// PIM_SATURATE_EN is defined.
package pim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } pim_mac_state_e;

    localparam int PIM_DEFAULT_N          = 8;
    localparam int PIM_DEFAULT_ELEM_WIDTH = 16;
    localparam int PIM_DEFAULT_ACC_WIDTH  = 32;

    // Signed add of two sign-extended operands, clamped to the range of a
    // two's-complement number of the given width (width must be <= 64).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [64:0] sum;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sum = 65'(a) + 65'(b);
        hi  = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo  = -hi - 65'sd1;
        if (sum > hi) begin
            return 64'(hi);
        end else if (sum < lo) begin
            return 64'(lo);
        end else begin
            return 64'(sum);
        end
    endfunction

endpackage

// File: rtl/pim_mac_cell.sv
// One accumulator lane of the tile MAC: multiplies one A and one B element
// at full precision and adds the product into its accumulator register.
// With PIM_SATURATE_EN defined the add clamps to the accumulator range,
// otherwise it wraps modulo 2^ACC_WIDTH.
module pim_mac_cell
    import pim_pkg::*;
#(
    parameter int ELEM_WIDTH = PIM_DEFAULT_ELEM_WIDTH,
    parameter int ACC_WIDTH  = PIM_DEFAULT_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [ELEM_WIDTH-1:0] a,
    input  logic signed [ELEM_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * ELEM_WIDTH;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum;

    assign prod     = PW'(a) * PW'(b);
    assign prod_ext = ACC_WIDTH'(prod);

`ifdef PIM_SATURATE_EN
    assign sum = ACC_WIDTH'(sat_add(64'(acc), 64'(prod_ext), ACC_WIDTH));
`else
    assign sum = acc + prod_ext;
`endif

    // Accumulator: reset and clear both start from zero; enable adds one product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/pim_tile_mac.sv
// Multi-cycle N x N tile multiply-accumulate. Accepts an A/B tile pair per
// handshake, applies one outer-product k-slice per cycle for N cycles and
// presents the tagged result until the aggregator takes it. The result
// register persists so a following in_acc=1 job chains onto it.
// Optional feature macro: PIM_SATURATE_EN (saturating accumulation).
module pim_tile_mac
    import pim_pkg::*;
#(
    parameter int ID              = 0,
    parameter int ELEM_WIDTH      = PIM_DEFAULT_ELEM_WIDTH,
    parameter int ACC_WIDTH       = PIM_DEFAULT_ACC_WIDTH,
    parameter int PIM_MATRIX_SIZE = PIM_DEFAULT_N,
    parameter int TAG_WIDTH       = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic                                                  in_acc,
    input  logic [TAG_WIDTH-1:0]                                  in_tag,
    input  logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] matrixA,
    input  logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] matrixB,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ACC_WIDTH-1:0]  result,
    output logic [TAG_WIDTH-1:0]                                  out_tag,
    output logic [7:0]                                            out_id,
    output logic                                                  busy
);

    localparam int N  = PIM_MATRIX_SIZE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if (ACC_WIDTH < 2 * ELEM_WIDTH) begin : g_bad_acc_width
        $error("pim_tile_mac: ACC_WIDTH must be at least 2*ELEM_WIDTH");
    end
    if (N < 2) begin : g_bad_size
        $error("pim_tile_mac: PIM_MATRIX_SIZE must be at least 2");
    end
`ifdef PIM_SATURATE_EN
    if (ACC_WIDTH > 64) begin : g_bad_sat_width
        $error("pim_tile_mac: saturating build supports ACC_WIDTH up to 64");
    end
`endif

    pim_mac_state_e                      state_q;
    logic [KW-1:0]                       k_q;
    logic [N-1:0][N-1:0][ELEM_WIDTH-1:0] a_q;
    logic [N-1:0][N-1:0][ELEM_WIDTH-1:0] b_q;
    logic [TAG_WIDTH-1:0]                tag_q;
    logic                                out_valid_q;
    logic                                busy_q;

    logic accept;
    logic acc_clear;
    logic acc_en;

    // in_ready is held low while rst is asserted so nothing is accepted in reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign acc_clear = accept && !in_acc;
    assign acc_en    = (state_q == COMPUTE);

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_tag   = tag_q;
    assign out_id    = 8'(ID);

    // Control FSM: capture on accept, step k through the slices, hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= matrixA;
                        b_q     <= matrixB;
                        tag_q   <= in_tag;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (k_q == K_LAST) begin
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            pim_mac_cell #(
                .ELEM_WIDTH (ELEM_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .clear (acc_clear),
                .en    (acc_en),
                .a     (a_q[i][k_q]),
                .b     (b_q[k_q][j]),
                .acc   (result[i][j])
            );
        end
    end

endmodule

// File: tb/tb_pim_tile_mac.sv
// Self-checking bench for pim_tile_mac: a reference model computes each
// job's tile from plain matrix arithmetic, pushes it on a scoreboard queue,
// and an independent monitor pops and compares on every output handshake.
module tb_pim_tile_mac;

    localparam int N      = 8;
    localparam int EW     = 16;
    localparam int AW     = 32;
    localparam int TW     = 4;
    localparam int ID_VAL = 5;

    typedef logic [N-1:0][N-1:0][EW-1:0] tile_t;
    typedef logic [N-1:0][N-1:0][AW-1:0] res_t;
    typedef struct {
        logic [TW-1:0] tag;
        res_t          res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_acc = 1'b0;
    logic [TW-1:0] in_tag = '0;
    tile_t         matrixA = '0;
    tile_t         matrixB = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    res_t          result;
    logic [TW-1:0] out_tag;
    logic [7:0]    out_id;
    logic          busy;

    exp_t   sb[$];
    longint modelAcc [N][N];
    int     checks = 0;
    int     failures = 0;
    bit     randReady = 1'b0;
    bit     readyForce = 1'b1;

    exp_t   monExp;
    int     monFi;
    int     monFj;
    bit     monBad;

    always #5 clk = ~clk;

    pim_tile_mac #(
        .ID              (ID_VAL),
        .ELEM_WIDTH      (EW),
        .ACC_WIDTH       (AW),
        .PIM_MATRIX_SIZE (N),
        .TAG_WIDTH       (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_tag    (in_tag),
        .matrixA   (matrixA),
        .matrixB   (matrixB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .out_id    (out_id),
        .busy      (busy)
    );

    // out_ready is either forced by the main sequence or randomised per cycle.
    always @(posedge clk) begin
        #2;
        out_ready = randReady ? ($urandom_range(0, 1) == 1) : readyForce;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One accumulate step of the reference: saturating or modulo-2^AW add.
    function automatic longint stepAdd(input longint s, input longint p);
        longint t;
        longint maxv;
        longint minv;
        t    = s + p;
        maxv = (longint'(1) <<< (AW - 1)) - 1;
        minv = -maxv - 1;
`ifdef PIM_SATURATE_EN
        if (t > maxv) t = maxv;
        if (t < minv) t = minv;
`else
        t = longint'(int'(t));
`endif
        return t;
    endfunction

    // Reference model: C = (acc ? C_prev : 0) + A*B, summed over k in order.
    task automatic modelJob(input bit acc, input logic [TW-1:0] tag, input tile_t a, input tile_t b);
        exp_t e;
        e.tag = tag;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = acc ? modelAcc[i][j] : 64'sd0;
                for (int k = 0; k < N; k++) begin
                    s = stepAdd(s, longint'($signed(a[i][k])) * longint'($signed(b[k][j])));
                end
                modelAcc[i][j] = s;
                e.res[i][j]    = AW'(s);
            end
        end
        sb.push_back(e);
    endtask

    function automatic tile_t identityTile();
        tile_t t;
        t = '0;
        for (int i = 0; i < N; i++) t[i][i] = EW'(1);
        return t;
    endfunction

    function automatic tile_t fillTile(input logic [EW-1:0] v);
        tile_t t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) t[i][j] = v;
        return t;
    endfunction

    function automatic tile_t rampTile();
        tile_t t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) t[i][j] = EW'(i * 8 + j);
        return t;
    endfunction

    function automatic tile_t randTile();
        tile_t t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) t[i][j] = EW'($urandom);
        return t;
    endfunction

    // Monitor: every output handshake pops one expected tile and compares it.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got tag 0x%0h expected no output", out_tag);
            end else begin
                monExp = sb.pop_front();
                checkOutput("out_tag", 64'(out_tag), 64'(monExp.tag));
                monBad = 1'b0;
                monFi  = 0;
                monFj  = 0;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (!monBad && (result[i][j] !== monExp.res[i][j])) begin
                            monBad = 1'b1;
                            monFi  = i;
                            monFj  = j;
                        end
                    end
                end
                checkOutput($sformatf("result[%0d][%0d]", monFi, monFj),
                            64'(result[monFi][monFj]), 64'(monExp.res[monFi][monFj]));
            end
        end
    end

    // Issue one job: wait (bounded) for in_ready, present it for one edge, record the expectation.
    task automatic applyStimulus(input bit acc, input logic [TW-1:0] tag, input tile_t a, input tile_t b);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
            return;
        end
        in_acc   = acc;
        in_tag   = tag;
        matrixA  = a;
        matrixB  = b;
        in_valid = 1'b1;
        modelJob(acc, tag, a, b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been taken.
    task automatic drain();
        int w;
        w = 0;
        @(posedge clk);
        while (sb.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) modelAcc[i][j] = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int  firstValid;
        int  busyCount;
        res_t snapRes;
        logic [TW-1:0] snapTag;
        int  w;
        logic [AW-1:0] ovfExp;

        clearModel();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_in_reset", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_result_zero", 64'(result == '0), 64'(1));
        checkOutput("reset_out_tag", 64'(out_tag), 64'(0));
        checkOutput("out_id", 64'(out_id), 64'(ID_VAL));
        @(posedge clk);
        #1;

        // Latency: identity * ramp, out_ready held high
        readyForce = 1'b1;
        applyStimulus(1'b0, 4'hA, identityTile(), rampTile());
        firstValid = -1;
        busyCount  = 0;
        for (int e = 0; e <= N + 1; e++) begin
            @(negedge clk);
            if (out_valid && firstValid < 0) firstValid = e;
            if (busy && e <= N) busyCount++;
            if (e == N + 1) begin
                checkOutput("busy_after_job", 64'(busy), 64'(0));
                checkOutput("in_ready_after_job", 64'(in_ready), 64'(1));
            end
        end
        checkOutput("latency_edges", 64'(firstValid), 64'(N));
        checkOutput("busy_during_job", 64'(busyCount), 64'(N + 1));
        @(posedge clk);
        #1;
        checkOutput("latency_result_b", 64'(result[3][5]), 64'(3 * 8 + 5));

        // Accumulate chaining: 1, then 2, then back to 1
        applyStimulus(1'b0, 4'h1, identityTile(), fillTile(16'd1));
        applyStimulus(1'b1, 4'h2, identityTile(), fillTile(16'd1));
        drain();
        checkOutput("acc_chain_two", 64'(result[7][0]), 64'(2));
        applyStimulus(1'b0, 4'h3, identityTile(), fillTile(16'd1));
        drain();
        checkOutput("acc_restart_one", 64'(result[4][4]), 64'(1));

        // Overflow
        applyStimulus(1'b0, 4'h4, fillTile(16'h7FFF), fillTile(16'h7FFF));
        drain();
`ifdef PIM_SATURATE_EN
        ovfExp = 32'h7FFF_FFFF;
`else
        ovfExp = 32'hFFF8_0008;
`endif
        checkOutput("overflow_value", 64'(result[2][6]), 64'(ovfExp));

        // Negative operands
        applyStimulus(1'b0, 4'h5, fillTile(16'hFFFF), fillTile(16'd3));
        drain();
        checkOutput("negative_value", 64'(result[6][1]), 64'(32'hFFFF_FFE8));

        // Back-pressure in DONE
        readyForce = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'h6, randTile(), randTile());
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_out_valid_reached", 64'(out_valid), 64'(1));
        snapRes = result;
        snapTag = out_tag;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_acc   = 1'($urandom);
            in_tag   = ~snapTag;
            matrixA  = randTile();
            matrixB  = randTile();
            @(negedge clk);
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp_result_stable", 64'(result == snapRes), 64'(1));
            checkOutput("bp_out_tag", 64'(out_tag), 64'(snapTag));
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        readyForce = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_at_release", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("bp_in_ready_after_release", 64'(in_ready), 64'(1));
        checkOutput("bp_out_valid_after_release", 64'(out_valid), 64'(0));

        // Reset mid-job at k=3
        applyStimulus(1'b0, 4'h7, randTile(), randTile());
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        clearModel();
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_result_zero", 64'(result == '0), 64'(1));
        checkOutput("midrst_out_tag", 64'(out_tag), 64'(0));
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'h8, identityTile(), fillTile(16'd5));
        drain();
        checkOutput("post_reset_acc", 64'(result[5][3]), 64'(5));

        // Randomised jobs with random back-pressure
        randReady = 1'b1;
        for (int n = 0; n < 24; n++) begin
            applyStimulus(1'($urandom), TW'($urandom), randTile(), randTile());
        end
        drain();
        randReady = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pim_tile_mac.md
# pim_tile_mac

Multi-cycle successor to the single-shot tile multiplier in the PIM datapath: accepts one PIM_MATRIX_SIZE×PIM_MATRIX_SIZE A/B tile pair per handshake and computes C = A·B over PIM_MATRIX_SIZE cycles, one k-slice (outer product) per cycle. It optionally accumulates onto the previous result, so a partition can chain k-tiles of a larger matrix. It sits between the partition and the result aggregator, with valid/ready on both sides and tagged results.

## Interface
- ID, 0: unit index; copied to out_id.
- ELEM_WIDTH, 16: signed two's-complement input element width.
- ACC_WIDTH, 32: signed accumulator/result width; must be ≥ 2·ELEM_WIDTH; elaboration error otherwise.
- PIM_MATRIX_SIZE, 8: tile dimension N; must be ≥ 2.
- TAG_WIDTH, 4: width of the job tag.
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  tile pair and controls valid.
- in_ready  out  1  unit can accept a tile pair.
- in_acc  in  1  1: start from the current result; 0: start from zero.
- in_tag  in  TAG_WIDTH  job tag, returned with the result.
- matrixA  in  ELEM_WIDTH × [N][N]  A tile.
- matrixB  in  ELEM_WIDTH × [N][N]  B tile.
- out_valid  out  1  result valid.
- out_ready  in  1  aggregator accepts the result.
- result  out  ACC_WIDTH × [N][N]  product/accumulated tile.
- out_tag  out  TAG_WIDTH  tag of the job that produced the result.
- out_id  out  8  ID constant.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch A, B, in_tag. If in_acc=0, zero the accumulators; if in_acc=1, keep them. k←0. Go to COMPUTE.
  - COMPUTE: each cycle, acc[i][j] ← acc[i][j] + A[i][k]·B[k][j] for all i,j. k increments. After k=N-1, go to DONE.
  - DONE: out_valid=1; result, out_tag stable. On out_ready, go to IDLE.
- result drives the accumulator registers directly.
- After the output handshake, result keeps its value until the next accept, and is used by the next in_acc=1 job.
- Arithmetic:
  - Products are full precision at 2·ELEM_WIDTH bits, sign-extended to ACC_WIDTH.
  - The overflow behaviour of the sum is set by the Configuration section.
- in_ready is 0 in COMPUTE and DONE. Inputs are ignored there, with no queueing.
- in_acc=1 after reset accumulates onto 0.

## Timing
- Accept edge at cycle 0. k-slices are applied on edges 1..N. out_valid is high from cycle N+1 until the out_ready handshake edge.
- Accept-to-out_valid latency is N+1 cycles. Minimum job spacing is N+2 cycles when out_ready is held at 1.
- out_valid and out_ready both high on the same edge: go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Reset values: in_ready=0 during reset and 1 after it; out_valid=0; busy=0; result=all 0; out_tag=0; k=0; state IDLE. out_id is constant.
- rst asserted at any point, including mid-COMPUTE or in DONE, aborts the job. The next cycle shows the reset values and no partial result.
- Back-pressure: while out_ready=0 in DONE, result, out_tag and out_valid hold indefinitely.

## Configuration
- PIM_SATURATE_EN defined: each add clamps to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Clamping is per k step and per accumulate step.
- PIM_SATURATE_EN undefined: the sum wraps modulo 2^ACC_WIDTH.

## Structure
- Shared package pim_pkg:
  - state enum pim_mac_state_e {IDLE, COMPUTE, DONE}.
  - default constants PIM_DEFAULT_N, PIM_DEFAULT_ELEM_WIDTH, PIM_DEFAULT_ACC_WIDTH.
  - function sat_add(a, b, width), used under PIM_SATURATE_EN.
- One sub-module, pim_mac_cell: a single accumulator register with multiply, add (saturate or wrap), clear and enable. The block instantiates it N×N times.
- FSM, k counter, A/B/tag capture and handshakes stay in pim_tile_mac.

## Test plan
- Latency: A=identity, B[i][j]=i·8+j, in_acc=0, accepted cycle 0, out_ready=1 → out_valid first high cycle 9 (N=8); result=B; out_tag=in_tag; busy high cycles 1–9.
- Accumulate: A=identity, B=all 1, in_acc=0 → result all 1. Repeat with in_acc=1 → all 2. Then in_acc=0 → all 1.
- Overflow: A=B=all 0x7FFF, in_acc=0.
  - PIM_SATURATE_EN defined → all 0x7FFFFFFF.
  - PIM_SATURATE_EN undefined → all 0xFFF80008.
- Negative values: A=all 0xFFFF (−1), B=all 3 → all −24 (0xFFFFFFE8) in both builds.
- Back-pressure: out_ready=0 for 5 cycles in DONE → out_valid, result, out_tag stable, in_ready=0, in_valid ignored. out_ready=1 → in_ready=1 the next cycle.
- Reset mid-job: rst pulsed while k=3 → next cycle out_valid=0, in_ready=1, busy=0, result=all 0. A following in_acc=1 job with A=identity, B=all 5 → all 5.
